// File: rtl/clock_text_gen_pkg.sv
// clock_text_pkg: character codes, text-box geometry and the snapshot record
// shared by the clock text overlay generator and its character selector.
package clock_text_pkg;

  // Character codes understood by the clock digit font ROM
  localparam logic [6:0] CH_ZERO  = 7'h30;
  localparam logic [6:0] CH_COLON = 7'h3A;
  localparam logic [6:0] CH_SPACE = 7'h20;
  localparam logic [6:0] CH_A     = 7'h40;
  localparam logic [6:0] CH_P     = 7'h41;
  localparam logic [6:0] CH_M     = 7'h4D;

  // Text box: 11 glyphs of 8x16 drawn at 2x scale
  localparam int N_CHARS = 11;
  localparam int CHAR_W  = 16;
  localparam int CHAR_H  = 32;

  // Frame-synchronous copy of the time shown on screen
  typedef struct packed {
    logic [3:0] hr_10;
    logic [3:0] hr_1;
    logic [3:0] min_10;
    logic [3:0] min_1;
    logic [3:0] sec_10;
    logic [3:0] sec_1;
    logic       pm;
  } time_snap_t;

  // BCD digit to character code; out-of-range digits show as a blank
  function automatic logic [6:0] bcd_to_char(input logic [3:0] d);
    if (d > 4'd9) begin
      return CH_SPACE;
    end
    return CH_ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/clock_text_gen_charsel.sv
// clock_text_charsel: maps a character position in "HH:MM:SS AM" to the
// font ROM character code. Purely combinational.
module clock_text_charsel
  import clock_text_pkg::*;
(
  input  logic [5:0]  char_idx,
  input  time_snap_t  snap,
  output logic [6:0]  char_code
);

  // Position decode; positions past the box edge fall back to a blank
  always_comb begin
    char_code = CH_SPACE;
    case (char_idx)
      6'd0:    char_code = bcd_to_char(snap.hr_10);
      6'd1:    char_code = bcd_to_char(snap.hr_1);
      6'd2:    char_code = CH_COLON;
      6'd3:    char_code = bcd_to_char(snap.min_10);
      6'd4:    char_code = bcd_to_char(snap.min_1);
      6'd5:    char_code = CH_COLON;
      6'd6:    char_code = bcd_to_char(snap.sec_10);
      6'd7:    char_code = bcd_to_char(snap.sec_1);
      6'd8:    char_code = CH_SPACE;
      6'd9:    char_code = snap.pm ? CH_P : CH_A;
      6'd10:   char_code = CH_M;
      default: char_code = CH_SPACE;
    endcase
  end

endmodule

// File: rtl/clock_text_gen.sv
// clock_text_gen: 2x-scaled "HH:MM:SS AM/PM" overlay feeding the clock font
// ROM. rom_addr is combinational from the pixel; rgb follows two clocks later.
// Define CLOCK_TEXT_BLINK_EN to blink the colons on tick_1hz.
module clock_text_gen
  import clock_text_pkg::*;
#(
  parameter logic [9:0]  X0     = 10'd192,
  parameter logic [9:0]  Y0     = 10'd224,
  parameter logic [9:0]  SNAP_Y = 10'd480,
  parameter logic [11:0] FG_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [3:0]  hr_10,
  input  logic [3:0]  hr_1,
  input  logic [3:0]  min_10,
  input  logic [3:0]  min_1,
  input  logic [3:0]  sec_10,
  input  logic [3:0]  sec_1,
  input  logic        pm,
  input  logic        tick_1hz,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [11:0] rgb
);

  localparam logic [10:0] BOX_W = 11'(N_CHARS * CHAR_W);
  localparam logic [10:0] BOX_H = 11'(CHAR_H);

  logic        in_box;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [5:0]  char_idx;
  logic [6:0]  char_code;
  logic        colon_mask;
  time_snap_t  snap_q, snap_d;

  // Box test done in 11 bits so the right/bottom limits never wrap
  assign in_box = ({1'b0, pixel_x} >= {1'b0, X0}) && ({1'b0, pixel_x} < ({1'b0, X0} + BOX_W)) &&
                  ({1'b0, pixel_y} >= {1'b0, Y0}) && ({1'b0, pixel_y} < ({1'b0, Y0} + BOX_H));

  assign dx       = in_box ? (pixel_x - X0) : 10'd0;
  assign dy       = in_box ? (pixel_y - Y0) : 10'd0;
  assign char_idx = dx[9:4];

  logic unused_bits;
  assign unused_bits = ^{dx[0], dy[9:5], dy[0]};

  // Snapshot loads once per frame so a time change never tears mid-frame
  always_comb begin
    snap_d = snap_q;
    if (pixel_y == SNAP_Y && pixel_x == 10'd0) begin
      snap_d = '{hr_10: hr_10, hr_1: hr_1, min_10: min_10, min_1: min_1,
                 sec_10: sec_10, sec_1: sec_1, pm: pm};
    end
  end

  // Snapshot register
  always_ff @(posedge clk) begin
    if (reset) snap_q <= '0;
    else       snap_q <= snap_d;
  end

  clock_text_charsel u_charsel (
    .char_idx  (char_idx),
    .snap      (snap_q),
    .char_code (char_code)
  );

  assign rom_addr = in_box ? {char_code, dy[4:1]} : 11'h000;

`ifdef CLOCK_TEXT_BLINK_EN
  logic colon_on_q, colon_on_d;

  // Colon visibility flips once per second
  always_comb begin
    colon_on_d = tick_1hz ? ~colon_on_q : colon_on_q;
  end

  // Colon visibility register; colons start visible
  always_ff @(posedge clk) begin
    if (reset) colon_on_q <= 1'b1;
    else       colon_on_q <= colon_on_d;
  end

  assign colon_mask = in_box && (char_idx == 6'd2 || char_idx == 6'd5) && !colon_on_q;
`else
  logic unused_tick;
  assign unused_tick = tick_1hz;
  assign colon_mask  = 1'b0;
`endif

  logic        video_on_q;
  logic        in_box_q;
  logic [2:0]  col_q;
  logic        colon_mask_q;
  logic [11:0] rgb_q, rgb_d;

  // Stage 1: hold pixel attributes while the ROM fetches the glyph row
  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_q   <= 1'b0;
      in_box_q     <= 1'b0;
      col_q        <= 3'd0;
      colon_mask_q <= 1'b0;
    end else begin
      video_on_q   <= video_on;
      in_box_q     <= in_box;
      col_q        <= dx[3:1];
      colon_mask_q <= colon_mask;
    end
  end

  // Stage 2 colour: pick the glyph bit, leftmost pixel is rom_data[7]
  always_comb begin
    rgb_d = BG_RGB;
    if (!video_on_q) begin
      rgb_d = 12'h000;
    end else if (in_box_q && rom_data[3'd7 - col_q] && !colon_mask_q) begin
      rgb_d = FG_RGB;
    end
  end

  // Output pixel register
  always_ff @(posedge clk) begin
    if (reset) rgb_q <= 12'h000;
    else       rgb_q <= rgb_d;
  end

  assign rgb = rgb_q;

endmodule

// File: tb/tb_clock_text_gen.sv
// Scoreboard bench for clock_text_gen: stimulus pushes the expected pixel,
// a monitor pops it two clocks later. Colon expectations follow
// CLOCK_TEXT_BLINK_EN.
module tb_clock_text_gen;

  localparam int X0     = 192;
  localparam int Y0     = 224;
  localparam int SNAP   = 480;
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;
`ifdef CLOCK_TEXT_BLINK_EN
  localparam logic [11:0] COLON_OFF = BG;
`else
  localparam logic [11:0] COLON_OFF = FG;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic [3:0]  hr_10 = '0, hr_1 = '0, min_10 = '0, min_1 = '0, sec_10 = '0, sec_1 = '0;
  logic        pm = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [11:0] rgb;

  int checks = 0;
  int fails  = 0;

  logic [11:0] exp_q[$];
  string       name_q[$];
  logic        tag = 1'b0, tag_d1 = 1'b0, tag_d2 = 1'b0;

  always #5 clk = ~clk;

  clock_text_gen dut (
    .clk(clk), .reset(reset), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .hr_10(hr_10), .hr_1(hr_1), .min_10(min_10), .min_1(min_1),
    .sec_10(sec_10), .sec_1(sec_1), .pm(pm), .tick_1hz(tick_1hz),
    .rom_addr(rom_addr), .rom_data(rom_data), .rgb(rgb)
  );

  // Tiny font: blank is empty, '1' and ':' have their real row 4, all else solid
  function automatic logic [7:0] font(input logic [6:0] c, input logic [3:0] r);
    if (c == 7'h20) return 8'h00;
    if (c == 7'h31 && r == 4'd4) return 8'b01111000;
    if (c == 7'h3A) return (r == 4'd4) ? 8'h18 : 8'h00;
    return 8'hFF;
  endfunction

  // Synchronous ROM model
  always @(posedge clk) rom_data <= font(rom_addr[10:4], rom_addr[3:0]);

  always @(posedge clk) begin
    tag_d1 <= tag;
    tag_d2 <= tag_d1;
  end

  // Monitor: compare rgb against the oldest expected pixel
  always @(posedge clk) begin
    logic [11:0] e;
    string n;
    #1;
    if (tag_d2) begin
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_empty: rgb=%h with no expected pixel", rgb);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (rgb !== e) begin
          fails++;
          $display("FAIL %s: rgb=%h required %h", n, rgb, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y, input logic von, input logic [11:0] exp,
                     input string nm, input bit chk, input logic [10:0] ea);
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    video_on = von;
    tag      = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #1;
    if (chk) begin
      checks++;
      if (rom_addr !== ea) begin
        fails++;
        $display("FAIL %s_addr: rom_addr=%h required %h", nm, rom_addr, ea);
      end
    end
    $display("pix %-18s x=%0d y=%0d von=%0b rom_addr=%h exp_rgb=%h", nm, x, y, von, rom_addr, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f, input logic p);
    hr_10 = a; hr_1 = b; min_10 = c; min_1 = d; sec_10 = e; sec_1 = f; pm = p;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [6:0]  c00 [11] = '{7'h30, 7'h30, 7'h3A, 7'h30, 7'h30, 7'h3A, 7'h30, 7'h30, 7'h20, 7'h40, 7'h4D};
  logic [11:0] r00 [11] = '{FG, FG, BG, FG, FG, BG, FG, FG, BG, FG, FG};

  initial begin
    // Reset: output forced to 0
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (rgb !== 12'h000) begin
        fails++;
        $display("FAIL reset_rgb: rgb=%h required 000", rgb);
      end
    end
    reset = 1'b0;

    // "00:00:00 AM" at font row 4, leftmost pixel of each glyph
    for (int i = 0; i < 11; i++)
      pix(X0 + 16*i, Y0 + 8, 1'b1, r00[i], "glyph00", 1'b1, {c00[i], 4'd4});
    pix(X0 + 38, Y0 + 8, 1'b1, FG, "colon_after_reset", 1'b1, 11'h3A4);
    pix(X0, Y0 + 31, 1'b1, FG, "bottom_row", 1'b1, 11'h30F);
    pix(X0, Y0 + 32, 1'b1, BG, "below_box", 1'b1, 11'h000);

    // Snapshot 12:34:56 PM, then sweep '1' at row 4
    set_time(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1);
    pix(0, SNAP, 1'b0, 12'h000, "snap_cycle", 1'b0, 11'h000);
    for (int d = 0; d < 16; d++)
      pix(X0 + d, Y0 + 8, 1'b1, (d >= 2 && d <= 9) ? FG : BG, "char1_row4", d == 0, 11'h314);
    pix(X0 + 64,  Y0 + 8, 1'b1, FG, "min_1_4", 1'b1, 11'h344);
    pix(X0 + 112, Y0 + 8, 1'b1, FG, "sec_1_6", 1'b1, 11'h364);
    pix(X0 + 144, Y0 + 8, 1'b1, FG, "pm_char", 1'b1, 11'h414);

    // Live time changes to 09:59:59 AM; display holds until the snapshot point
    set_time(4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 1'b0);
    pix(X0, Y0 + 8, 1'b1, BG, "no_tear", 1'b1, 11'h314);
    pix(X0 + 144, Y0 + 8, 1'b1, FG, "no_tear_pm", 1'b1, 11'h414);
    pix(0, SNAP - 1, 1'b0, 12'h000, "pre_snap_line", 1'b0, 11'h000);
    pix(1, SNAP, 1'b0, 12'h000, "snap_line_x1", 1'b0, 11'h000);
    pix(X0, Y0 + 8, 1'b1, BG, "no_tear2", 1'b1, 11'h314);
    pix(0, SNAP, 1'b0, 12'h000, "snap_cycle2", 1'b0, 11'h000);
    pix(X0, Y0 + 8, 1'b1, FG, "after_snap", 1'b1, 11'h304);
    pix(X0 + 16, Y0 + 8, 1'b1, FG, "after_snap_hr1", 1'b1, 11'h394);
    pix(X0 + 144, Y0 + 8, 1'b1, FG, "after_snap_am", 1'b1, 11'h404);

    // Colon blink: one tick hides, a second restores
    tick_1hz = 1'b1;
    pix(0, 0, 1'b0, 12'h000, "tick1", 1'b0, 11'h000);
    tick_1hz = 1'b0;
    for (int x = 38; x <= 41; x++)
      pix(X0 + x, Y0 + 8, 1'b1, COLON_OFF, "colon_off", x == 38, 11'h3A4);
    pix(X0 + 86, Y0 + 8, 1'b1, COLON_OFF, "colon2_off", 1'b1, 11'h3A4);
    tick_1hz = 1'b1;
    pix(0, 0, 1'b0, 12'h000, "tick2", 1'b0, 11'h000);
    tick_1hz = 1'b0;
    for (int x = 38; x <= 41; x++)
      pix(X0 + x, Y0 + 8, 1'b1, FG, "colon_on", x == 38, 11'h3A4);

    // Blanking and box edges
    pix(X0 + 2, Y0 + 8, 1'b0, 12'h000, "video_off", 1'b1, 11'h304);
    pix(X0 - 1, Y0 + 8, 1'b1, BG, "left_edge", 1'b1, 11'h000);
    pix(X0 + 176, Y0 + 8, 1'b1, BG, "right_edge", 1'b1, 11'h000);
    pix(X0 + 175, Y0 + 8, 1'b1, FG, "last_col", 1'b1, 11'h4D4);

    // Invalid BCD blanks a glyph; tick in the snapshot cycle also lands
    min_1 = 4'hA;
    tick_1hz = 1'b1;
    pix(0, SNAP, 1'b0, 12'h000, "snap_tick", 1'b0, 11'h000);
    tick_1hz = 1'b0;
    pix(X0 + 64, Y0 + 8, 1'b1, BG, "bcd_blank_l", 1'b1, 11'h204);
    pix(X0 + 70, Y0 + 8, 1'b1, BG, "bcd_blank_m", 1'b1, 11'h204);
    pix(X0 + 79, Y0 + 8, 1'b1, BG, "bcd_blank_r", 1'b1, 11'h204);
    pix(X0 + 48, Y0 + 8, 1'b1, FG, "min_10_5", 1'b1, 11'h354);
    pix(X0 + 38, Y0 + 8, 1'b1, COLON_OFF, "colon_tick_snap", 1'b1, 11'h3A4);

    // Reset mid-frame: two blank outputs, then normal with cleared state
    pix(X0 + 2, Y0 + 8, 1'b1, 12'h000, "reset_flush1", 1'b0, 11'h000);
    reset = 1'b1;
    pix(X0 + 2, Y0 + 8, 1'b1, 12'h000, "reset_flush2", 1'b0, 11'h000);
    reset = 1'b0;
    pix(X0 + 2, Y0 + 8, 1'b1, FG, "post_reset", 1'b1, 11'h304);
    pix(X0 + 38, Y0 + 8, 1'b1, FG, "post_reset_colon", 1'b1, 11'h3A4);
    pix(X0 + 144, Y0 + 8, 1'b1, FG, "post_reset_am", 1'b1, 11'h404);

    // Drain the pipeline and confirm every expected pixel was seen
    tag = 1'b0;
    video_on = 1'b0;
    repeat (4) step();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected pixels left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
